// File: rtl/blit_cmd_arb.sv
// blit_cmd_arb: two-requester batch-locking arbiter feeding a small command FIFO for the blitter.
// Optional idle-lock revocation is built only when BLIT_ARB_TIMEOUT_EN is defined.
module blit_cmd_arb #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [95:0] r0_cmd,
   input  logic        r0_valid,
   input  logic        r0_last,
   output logic        r0_ready,
   input  logic [95:0] r1_cmd,
   input  logic        r1_valid,
   input  logic        r1_last,
   output logic        r1_ready,
   output logic [95:0] cmd,
   output logic        cmd_valid,
   input  logic        next_cmd,
   input  logic        blit_idle,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        lock_timeout
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t        state;
   logic          rr;
   logic [95:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic          not_full;
   logic          own_valid;
   logic          own_last;
   logic [95:0]   own_cmd;
   logic          push;
   logic          pop;
   logic          release_lock;
   logic          revoke;

   assign not_full     = count < DEPTH_C;
   assign r0_ready     = (state == OWN0) && not_full;
   assign r1_ready     = (state == OWN1) && not_full;
   assign grant        = {state == OWN1, state == OWN0};
   assign cmd_valid    = count != '0;
   assign cmd          = mem[rd_ptr];
   assign busy         = cmd_valid || (state != IDLE) || !blit_idle;
   assign push         = own_valid && not_full;
   assign pop          = next_cmd && cmd_valid;
   assign release_lock = push && own_last;

   // Only the lock owner's beat stream is visible; the other requester is ignored entirely.
   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_cmd   = r0_cmd;
      case (state)
         OWN0: begin
            own_valid = r0_valid;
            own_last  = r0_last;
            own_cmd   = r0_cmd;
         end
         OWN1: begin
            own_valid = r1_valid;
            own_last  = r1_last;
            own_cmd   = r1_cmd;
         end
         default: ;
      endcase
   end

`ifdef BLIT_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] idle_cnt;
   logic          timeout_flag;

   assign revoke       = (state != IDLE) && !own_valid && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign lock_timeout = timeout_flag;

   // Counts owner-silent cycles; held (not cleared) while a beat is stalled by a full FIFO.
   always_ff @(posedge clock) begin
      if (reset) begin
         idle_cnt     <= '0;
         timeout_flag <= 1'b0;
      end else begin
         if (state == IDLE || revoke || push)
            idle_cnt <= '0;
         else if (!own_valid)
            idle_cnt <= idle_cnt + 1'b1;
         if (revoke)
            timeout_flag <= 1'b1;
      end
   end
`else
   assign revoke       = 1'b0;
   assign lock_timeout = 1'b0;
`endif

   // rr = 1 favours requester 1; every lock release hands priority to the other side.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         rr    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (r0_valid && (!r1_valid || !rr))
                  state <= OWN0;
               else if (r1_valid)
                  state <= OWN1;
            end
            OWN0, OWN1: begin
               if (release_lock || revoke) begin
                  state <= IDLE;
                  rr    <= (state == OWN0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= own_cmd;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/blit_cmd_arb.md
# blit_cmd_arb

Command arbiter and buffer in front of `blit_command`. Two requesters share the single blitter command port: requester 0 is CPU register writes and requester 1 is the display-list fetcher. Blitter state (dest, clip, offset, colour, src) is shared between them, so the arbiter grants whole batches: a requester keeps the lock from its first beat until it delivers a beat flagged `last`. Accepted commands go into a small FIFO that drives `cmd`/`cmd_valid` and is popped by the blitter's `next_cmd` pulse.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, >= 2.
- `TIMEOUT_CYCLES`, 256: idle-lock timeout; used only with `BLIT_ARB_TIMEOUT_EN`.

- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `r0_cmd` in 96: requester 0 command; [7:0] opcode, [63:32] arg1, [95:64] arg2.
- `r0_valid` in 1: requester 0 command present.
- `r0_last` in 1: this beat ends requester 0's batch.
- `r0_ready` out 1: requester 0 beat accepted when `r0_valid && r0_ready`.
- `r1_cmd` / `r1_valid` / `r1_last` / `r1_ready`: same as r0, for requester 1.
- `cmd` out 96: FIFO head, to the blitter.
- `cmd_valid` out 1: FIFO non-empty.
- `next_cmd` in 1: single-cycle pop pulse from the blitter.
- `blit_idle` in 1: blitter pipeline idle (`p5_idle`).
- `grant` out 2: one-hot current lock owner; 00 when no one holds the lock.
- `busy` out 1: `cmd_valid || grant!=0 || !blit_idle`; combinational.
- `lock_timeout` out 1: sticky flag, set when a lock is revoked.

## Operation
- Arbiter state machine states:
  - IDLE: no owner.
  - OWN0: requester 0 holds the lock.
  - OWN1: requester 1 holds the lock.
- `grant` is decoded from the state: 00, 01, 10.
- IDLE: if any `rX_valid` is high, move to OWNx on the next cycle. No beat is accepted in IDLE.
- Round-robin pointer `rr`:
  - Reset value favours r0.
  - When both requesters are valid in IDLE, the one `rr` favours wins.
  - On every lock release, `rr` moves to the other requester.
- OWNx:
  - `rX_ready = (count < FIFO_DEPTH)`. The other requester's ready is 0.
  - An accepted beat is pushed to the FIFO tail.
  - An accepted beat with `rX_last` set moves the state to IDLE. Every batch therefore costs one IDLE cycle.
- Non-owner `valid` is ignored; its `cmd` may change freely.
- FIFO:
  - `cmd` is the registered head entry. `cmd_valid = (count != 0)`.
  - `next_cmd` pops the head. `next_cmd` while empty is ignored.
  - A push and a pop in the same cycle leave `count` unchanged; the ordering is preserved.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. `count` is `$clog2(FIFO_DEPTH)+1` bits.
- Opcodes are not inspected; the arbiter is command-agnostic.
- Reset values:
  - State IDLE, `rr` favouring r0, FIFO empty.
  - `cmd_valid` = 0, `grant` = 00, `r0_ready` = `r1_ready` = 0, `lock_timeout` = 0.
  - `busy` follows `blit_idle`.
  - `cmd` is don't-care.

## Timing
- Request to grant: `rX_valid` rising in IDLE gives `grant` on the next edge. The first beat is accepted in that following cycle at the earliest.
- Accept to visible: a beat pushed into an empty FIFO shows `cmd_valid` = 1 one cycle later.
- Ready: combinational from registered `count` and state.
  - At full, ready is 0.
  - After a `next_cmd` pop, ready rises in the next cycle.
- Throughput: one beat per cycle while not full.
- The blitter pops at most one command per two cycles (`next_cmd` followed by WAIT); the FIFO absorbs the rate difference.
- Reset mid-operation:
  - FIFO contents are discarded, the lock is dropped, and `cmd_valid` = 0 the cycle after reset.
  - Requesters re-issue whole batches.

## Configuration
- Macro: `BLIT_ARB_TIMEOUT_EN`.
- Defined:
  - A counter runs in OWNx while the owner's `valid` is low. It clears on each accepted beat and on entering OWNx.
  - When the count reaches `TIMEOUT_CYCLES`, the state goes to IDLE, `rr` moves to the other requester, and `lock_timeout` is set. It stays set until reset.
  - FIFO contents are kept.
- Undefined:
  - A lock is held indefinitely until `last`.
  - `lock_timeout` is tied to 0 and the counter is not built.

## Test plan
- r0 sends opcodes 01, 04, 05 (last on 05), `next_cmd` pulses every 2 cycles -> `grant` = 01 the cycle after valid; `cmd` presents 01, 04, 05 in order; `grant` = 00 after 05 is accepted; `busy` drops when the FIFO is empty and `blit_idle` = 1.
- Both requesters valid from reset, each sending 2-beat batches repeatedly -> order is r0 batch, r1 batch, r0 batch; exactly one IDLE cycle between batches.
- r1 mid-batch (1 of 3 beats sent, then pausing 5 cycles) while r0 is valid -> `r0_ready` stays 0 until r1's `last` beat is accepted; r0 is granted the cycle after.
- FIFO_DEPTH=4, no `next_cmd`, r0 streams 6 beats -> 4 accepted, then `r0_ready` = 0; one `next_cmd` pulse -> `r0_ready` = 1 the next cycle and beat 5 is accepted; the head sequence is intact.
- `BLIT_ARB_TIMEOUT_EN`, r0 sends 1 non-last beat then drops valid with r1 valid -> after 256 cycles `grant` = 00, `lock_timeout` = 1, then `grant` = 10; the r0 beat is still delivered first.
- Reset asserted with 3 entries queued and r1 owning the lock -> next cycle `cmd_valid` = 0, `grant` = 00, `lock_timeout` = 0.
